// File: rtl/psola_frame_scheduler_if.sv
// Signal bundle between the PSOLA frame scheduler and its environment:
// the window buffer, the pitch detector, the PSOLA core and the DAC-side FIFO.
interface psola_frame_scheduler_if;
    logic        frame_ready_in;
    logic        period_valid_in;
    logic [11:0] period_in;
    logic        psola_start_out;
    logic [11:0] psola_period_out;
    logic        psola_done_in;
    logic [11:0] psola_len_in;
    logic        frame_lock_out;
    logic [12:0] rd_addr_out;
    logic [31:0] sample_in;
    logic [31:0] sample_out;
    logic        sample_valid_out;
    logic        sample_ready_in;
    logic        busy_out;
    logic [15:0] overrun_cnt_out;
    logic        timeout_err_out;

    modport master (
        input  frame_ready_in, period_valid_in, period_in, psola_done_in, psola_len_in,
               sample_in, sample_ready_in,
        output psola_start_out, psola_period_out, frame_lock_out, rd_addr_out,
               sample_out, sample_valid_out, busy_out, overrun_cnt_out, timeout_err_out
    );

    modport slave (
        output frame_ready_in, period_valid_in, period_in, psola_done_in, psola_len_in,
               sample_in, sample_ready_in,
        input  psola_start_out, psola_period_out, frame_lock_out, rd_addr_out,
               sample_out, sample_valid_out, busy_out, overrun_cnt_out, timeout_err_out
    );
endinterface

// File: rtl/psola_frame_scheduler.sv
// Pairs each captured window with a pitch period, runs one PSOLA core pass,
// then streams the core's output window downstream over valid/ready.
//
// state       | meaning
// IDLE        | no frame in flight
// WAIT_PERIOD | frame accepted, waiting for a pitch period
// LAUNCH      | one-cycle start pulse, period presented to the core
// RUN         | core working; watchdog timer running
// DRAIN       | streaming core output samples 0..len-1
module psola_frame_scheduler #(
    parameter int WINDOW_SIZE    = 2048,
    parameter int MIN_PERIOD     = 20,
    parameter int MAX_PERIOD     = 1000,
    parameter int DEFAULT_PERIOD = 100,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic                    clk_in,
    input logic                    rst_in,
    psola_frame_scheduler_if.master bus
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [12:0]   LEN_MAX    = 13'(2 * WINDOW_SIZE);

    typedef enum logic [2:0] {IDLE, WAIT_PERIOD, LAUNCH, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [12:0] rd_addr_q, rd_addr_d;
    logic [12:0] len_q, len_d;
    logic [11:0] period_reg_q, period_reg_d;
    logic [11:0] period_out_q, period_out_d;
    logic        period_flag_q, period_flag_d;
    logic        pending_q, pending_d;
    logic [15:0] overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic        enter_launch;
    logic        period_ok;
    logic [12:0] len_clamped;

    assign period_ok = bus.period_valid_in &&
                       (bus.period_in >= 12'(MIN_PERIOD)) &&
                       (bus.period_in <= 12'(MAX_PERIOD));
    assign len_clamped = ({1'b0, bus.psola_len_in} > LEN_MAX) ? LEN_MAX : {1'b0, bus.psola_len_in};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            rd_addr_q     <= '0;
            len_q         <= '0;
            period_reg_q  <= 12'(DEFAULT_PERIOD);
            period_out_q  <= 12'(DEFAULT_PERIOD);
            period_flag_q <= 1'b0;
            pending_q     <= 1'b0;
            overrun_q     <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rd_addr_q     <= rd_addr_d;
            len_q         <= len_d;
            period_reg_q  <= period_reg_d;
            period_out_q  <= period_out_d;
            period_flag_q <= period_flag_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        rd_addr_d    = rd_addr_q;
        len_d        = len_q;
        period_out_d = period_out_q;
        timeout_d    = timeout_q;
        enter_launch = 1'b0;
        case (state_q)
            IDLE: if (bus.frame_ready_in || pending_q) state_d = WAIT_PERIOD;
            WAIT_PERIOD: if (period_flag_q || bus.period_valid_in) begin
                state_d      = LAUNCH;
                enter_launch = 1'b1;
                // a period arriving this very cycle must reach the core
                period_out_d = period_ok ? bus.period_in : period_reg_q;
            end
            LAUNCH: begin
                state_d = RUN;
                timer_d = '0;
            end
            RUN: begin
                // timer_q==0 marks the first RUN cycle, where done is stale
                if ((timer_q != '0) && bus.psola_done_in) begin
                    len_d     = len_clamped;
                    rd_addr_d = '0;
                    state_d   = (len_clamped == '0) ? IDLE : DRAIN;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DRAIN: if (bus.sample_ready_in) begin
                if (rd_addr_q == len_q - 13'd1) state_d = IDLE;
                else rd_addr_d = rd_addr_q + 13'd1;
            end
            default: state_d = IDLE;
        endcase

        period_reg_d  = period_ok ? bus.period_in : period_reg_q;
        period_flag_d = enter_launch ? 1'b0 : (bus.period_valid_in ? 1'b1 : period_flag_q);

        pending_d = pending_q;
        overrun_d = overrun_q;
        if (state_q == IDLE) begin
            pending_d = pending_q && bus.frame_ready_in;
        end else if (bus.frame_ready_in) begin
            pending_d = 1'b1;
            if (pending_q && (overrun_q != 16'hFFFF)) overrun_d = overrun_q + 16'd1;
        end
    end

    assign bus.psola_start_out  = (state_q == LAUNCH);
    assign bus.frame_lock_out   = (state_q == LAUNCH) || (state_q == RUN) || (state_q == DRAIN);
    assign bus.busy_out         = (state_q != IDLE);
    assign bus.sample_valid_out = (state_q == DRAIN);
    assign bus.rd_addr_out      = (state_q == DRAIN) ? rd_addr_q : '0;
    assign bus.sample_out       = (state_q == DRAIN) ? bus.sample_in : '0;
    assign bus.psola_period_out = period_out_q;
    assign bus.overrun_cnt_out  = overrun_q;
    assign bus.timeout_err_out  = timeout_q;
endmodule

// File: tb/tb_psola_frame_scheduler.sv
// Directed bench for psola_frame_scheduler: launch timing, draining with
// backpressure, overrun/pending handling, period bounds, timeout and reset.
module tb_psola_frame_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    psola_frame_scheduler_if bus();

    psola_frame_scheduler dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    always #5 clk = ~clk;

    // core output array model: word k holds CAFE0000+k
    assign bus.sample_in = 32'hCAFE_0000 + {19'b0, bus.rd_addr_out};

    task automatic launch_frame(input logic [11:0] p);
        bus.period_valid_in = 1'b1; bus.period_in = p;
        @(negedge clk);
        bus.period_valid_in = 1'b0; bus.frame_ready_in = 1'b1;
        @(negedge clk);
        bus.frame_ready_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic finish_core(input logic [11:0] len);
        int n;
        n = 0;
        bus.psola_len_in = len; bus.psola_done_in = 1'b1;
        @(negedge clk);
        while (!(bus.sample_valid_out || !bus.busy_out) && n < 8) begin
            n++;
            @(negedge clk);
        end
        bus.psola_done_in = 1'b0;
        total++; if (n >= 8) begin bad++; $display("FAIL done_wait got=timeout want=drain_or_idle len=%0d", len); end
    endtask

    task automatic pulse_frame();
        bus.frame_ready_in = 1'b1;
        @(negedge clk);
        bus.frame_ready_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++; if (bus.psola_start_out !== 1'b0) begin bad++; $display("FAIL rst_start got=%0h want=0", bus.psola_start_out); end
        total++; if (bus.psola_period_out !== 12'd100) begin bad++; $display("FAIL rst_period got=%0d want=100", bus.psola_period_out); end
        total++; if (bus.busy_out !== 1'b0 || bus.frame_lock_out !== 1'b0) begin bad++; $display("FAIL rst_busy_lock got=%0b%0b want=00", bus.busy_out, bus.frame_lock_out); end
        total++; if (bus.overrun_cnt_out !== 16'd0 || bus.timeout_err_out !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h/%0h want=0/0", bus.overrun_cnt_out, bus.timeout_err_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_launch();
        bus.period_valid_in = 1'b1; bus.period_in = 12'd200;
        @(negedge clk);
        bus.period_valid_in = 1'b0; bus.frame_ready_in = 1'b1;
        @(negedge clk);
        bus.frame_ready_in = 1'b0;
        total++; if (bus.busy_out !== 1'b1 || bus.psola_start_out !== 1'b0) begin bad++; $display("FAIL launch_wait got=busy%0b start%0b want=busy1 start0", bus.busy_out, bus.psola_start_out); end
        @(negedge clk);
        total++; if (bus.psola_start_out !== 1'b1) begin bad++; $display("FAIL launch_start got=%0b want=1", bus.psola_start_out); end
        total++; if (bus.psola_period_out !== 12'd200) begin bad++; $display("FAIL launch_period got=%0d want=200", bus.psola_period_out); end
        total++; if (bus.frame_lock_out !== 1'b1) begin bad++; $display("FAIL launch_lock got=%0b want=1", bus.frame_lock_out); end
        @(negedge clk);
        total++; if (bus.psola_start_out !== 1'b0 || bus.frame_lock_out !== 1'b1) begin bad++; $display("FAIL run_start_lock got=%0b%0b want=01", bus.psola_start_out, bus.frame_lock_out); end
    endtask

    task automatic test_drain_len5();
        bus.sample_ready_in = 1'b1;
        finish_core(12'd5);
        for (int k = 0; k < 5; k++) begin
            total++; if (bus.sample_valid_out !== 1'b1 || bus.rd_addr_out !== 13'(k)) begin bad++; $display("FAIL drain5_addr got=v%0b a%0d want=v1 a%0d", bus.sample_valid_out, bus.rd_addr_out, k); end
            total++; if (bus.sample_out !== 32'hCAFE_0000 + 32'(k)) begin bad++; $display("FAIL drain5_data got=%0h want=%0h", bus.sample_out, 32'hCAFE_0000 + 32'(k)); end
            @(negedge clk);
        end
        total++; if (bus.busy_out !== 1'b0 || bus.frame_lock_out !== 1'b0 || bus.sample_valid_out !== 1'b0) begin bad++; $display("FAIL drain5_end got=b%0b l%0b v%0b want=000", bus.busy_out, bus.frame_lock_out, bus.sample_valid_out); end
        bus.sample_ready_in = 1'b0;
    endtask

    task automatic test_ready_toggle();
        logic [6:0] pat;
        int exp_rd;
        pat = 7'b1010101;
        exp_rd = 0;
        launch_frame(12'd300);
        finish_core(12'd4);
        for (int i = 0; i < 7; i++) begin
            total++; if (bus.sample_valid_out !== 1'b1 || bus.rd_addr_out !== 13'(exp_rd)) begin bad++; $display("FAIL toggle_addr step=%0d got=v%0b a%0d want=v1 a%0d", i, bus.sample_valid_out, bus.rd_addr_out, exp_rd); end
            total++; if (bus.sample_out !== 32'hCAFE_0000 + 32'(exp_rd)) begin bad++; $display("FAIL toggle_data step=%0d got=%0h want=%0h", i, bus.sample_out, 32'hCAFE_0000 + 32'(exp_rd)); end
            bus.sample_ready_in = pat[6-i];
            @(negedge clk);
            if (pat[6-i]) exp_rd++;
        end
        bus.sample_ready_in = 1'b0;
        total++; if (bus.sample_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin bad++; $display("FAIL toggle_end got=v%0b b%0b want=v0 b0", bus.sample_valid_out, bus.busy_out); end
    endtask

    task automatic test_overrun();
        launch_frame(12'd150);
        pulse_frame();
        pulse_frame();
        bus.period_valid_in = 1'b1; bus.period_in = 12'd250;
        @(negedge clk);
        bus.period_valid_in = 1'b0;
        pulse_frame();
        total++; if (bus.overrun_cnt_out !== 16'd2) begin bad++; $display("FAIL overrun_cnt got=%0d want=2", bus.overrun_cnt_out); end
        bus.sample_ready_in = 1'b1;
        finish_core(12'd2);
        total++; if (bus.rd_addr_out !== 13'd0) begin bad++; $display("FAIL ovr_drain0 got=%0d want=0", bus.rd_addr_out); end
        @(negedge clk);
        total++; if (bus.rd_addr_out !== 13'd1) begin bad++; $display("FAIL ovr_drain1 got=%0d want=1", bus.rd_addr_out); end
        @(negedge clk);
        total++; if (bus.busy_out !== 1'b0 || bus.frame_lock_out !== 1'b0) begin bad++; $display("FAIL ovr_idle got=b%0b l%0b want=00", bus.busy_out, bus.frame_lock_out); end
        @(negedge clk);
        total++; if (bus.busy_out !== 1'b1 || bus.psola_start_out !== 1'b0) begin bad++; $display("FAIL ovr_wait got=b%0b s%0b want=b1 s0", bus.busy_out, bus.psola_start_out); end
        @(negedge clk);
        total++; if (bus.psola_start_out !== 1'b1 || bus.psola_period_out !== 12'd250) begin bad++; $display("FAIL ovr_relaunch got=s%0b p%0d want=s1 p250", bus.psola_start_out, bus.psola_period_out); end
        @(negedge clk);
        bus.sample_ready_in = 1'b0;
        finish_core(12'd0);
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL ovr_no_third step=%0d got=%0b want=0", i, bus.busy_out); end
            @(negedge clk);
        end
        total++; if (bus.overrun_cnt_out !== 16'd2) begin bad++; $display("FAIL overrun_hold got=%0d want=2", bus.overrun_cnt_out); end
    endtask

    task automatic test_period_bounds();
        logic [11:0] req [4];
        logic [11:0] exp [4];
        req = '{12'd1000, 12'd1001, 12'd20, 12'd19};
        exp = '{12'd1000, 12'd1000, 12'd20, 12'd20};
        for (int i = 0; i < 4; i++) begin
            launch_frame(req[i]);
            total++; if (bus.psola_period_out !== exp[i]) begin bad++; $display("FAIL period_bound req=%0d got=%0d want=%0d", req[i], bus.psola_period_out, exp[i]); end
            finish_core(12'd0);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch_frame(12'd5);
        total++; if (bus.psola_period_out !== 12'd100) begin bad++; $display("FAIL period_default got=%0d want=100", bus.psola_period_out); end
        total++; if (bus.timeout_err_out !== 1'b0) begin bad++; $display("FAIL timeout_early got=%0b want=0", bus.timeout_err_out); end
        cnt = 0;
        while (bus.busy_out && cnt < 70000) begin
            cnt++;
            @(negedge clk);
        end
        total++; if (cnt !== 65536) begin bad++; $display("FAIL timeout_cycles got=%0d want=65536", cnt); end
        total++; if (bus.timeout_err_out !== 1'b1 || bus.busy_out !== 1'b0) begin bad++; $display("FAIL timeout_flag got=t%0b b%0b want=t1 b0", bus.timeout_err_out, bus.busy_out); end
    endtask

    task automatic test_reset_mid_drain();
        launch_frame(12'd200);
        pulse_frame();
        pulse_frame();
        finish_core(12'd8);
        total++; if (bus.sample_valid_out !== 1'b1 || bus.overrun_cnt_out !== 16'd1) begin bad++; $display("FAIL pre_reset got=v%0b o%0d want=v1 o1", bus.sample_valid_out, bus.overrun_cnt_out); end
        rst = 1'b1;
        #1;
        total++; if (bus.sample_valid_out !== 1'b0 || bus.frame_lock_out !== 1'b0 || bus.busy_out !== 1'b0) begin bad++; $display("FAIL arst_ctrl got=v%0b l%0b b%0b want=000", bus.sample_valid_out, bus.frame_lock_out, bus.busy_out); end
        total++; if (bus.rd_addr_out !== 13'd0 || bus.sample_out !== 32'd0) begin bad++; $display("FAIL arst_data got=a%0d d%0h want=0/0", bus.rd_addr_out, bus.sample_out); end
        total++; if (bus.overrun_cnt_out !== 16'd0 || bus.timeout_err_out !== 1'b0) begin bad++; $display("FAIL arst_err got=o%0d t%0b want=0/0", bus.overrun_cnt_out, bus.timeout_err_out); end
        total++; if (bus.psola_period_out !== 12'd100) begin bad++; $display("FAIL arst_period got=%0d want=100", bus.psola_period_out); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL arst_pending step=%0d got=%0b want=0", i, bus.busy_out); end
        end
    endtask

    initial begin
        bus.frame_ready_in  = 1'b0;
        bus.period_valid_in = 1'b0;
        bus.period_in       = 12'd0;
        bus.psola_done_in   = 1'b0;
        bus.psola_len_in    = 12'd0;
        bus.sample_ready_in = 1'b0;
        test_reset();
        test_launch();
        test_drain_len5();
        test_ready_toggle();
        test_overrun();
        test_period_bounds();
        test_timeout();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
